// File: rtl/fft_pkg.sv
// Shared FFT datapath types and defaults used by the twiddle multiplier scheduling logic.
package fft_pkg;

  localparam int unsigned DATA_W            = 16;
  localparam int unsigned CMULT_LAT_DEFAULT = 1;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
  } cmult_ops_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a pointer that only moves on contested grants.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] req_valid,
  output logic [1:0] grant_c
);

  logic rr;

  // At most one grant; nothing is granted while flushing or held in reset
  always_comb begin
    grant_c = 2'b00;
    if (rst_n && !flush) begin
      case (req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (!flush && (&req_valid)) begin
      rr <= ~rr;
    end
  end

endmodule

// File: rtl/cmult_arbiter.sv
// Shares one pipelined complex multiplier between two requesters and routes results back by owner.
// Optional per-requester grant counters are enabled with CMULT_ARB_STATS_EN.
module cmult_arbiter
  import fft_pkg::*;
#(
  parameter int unsigned MULT_LAT = CMULT_LAT_DEFAULT,
  parameter int unsigned DATA_W   = fft_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][4*DATA_W-1:0]   req_ops,
  output logic [DATA_W-1:0]          m_a_r,
  output logic [DATA_W-1:0]          m_a_i,
  output logic [DATA_W-1:0]          m_b_r,
  output logic [DATA_W-1:0]          m_b_i,
  input  logic [DATA_W-1:0]          mr_r,
  input  logic [DATA_W-1:0]          mr_i,
  output logic [1:0]                 res_valid,
  output logic [DATA_W-1:0]          res_r,
  output logic [DATA_W-1:0]          res_i,
  output logic                       busy
`ifdef CMULT_ARB_STATS_EN
  ,
  output logic [1:0][15:0]           grant_cnt
`endif
);

  localparam int unsigned OPS_W  = 4 * DATA_W;
  localparam int unsigned SR_LEN = MULT_LAT + 1;

  logic [1:0]        grant_c;
  logic              xfer_c;
  logic              gnt_idx_c;
  logic [OPS_W-1:0]  ops_sel_c;

  logic [SR_LEN-1:0] sr_vld;
  logic [SR_LEN-1:0] sr_own;
  logic [SR_LEN-1:0] sr_vld_nxt_c;
  logic [SR_LEN-1:0] sr_own_nxt_c;
  logic              res_fire_c;
  logic [1:0]        res_valid_nxt_c;
  logic              busy_nxt_c;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .grant_c   (grant_c)
  );

  assign req_ready = grant_c;
  assign xfer_c    = |grant_c;
  assign gnt_idx_c = grant_c[1];
  assign ops_sel_c = req_ops[gnt_idx_c];

  // Operand stage feeding the external multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_a_r, m_a_i, m_b_r, m_b_i} <= '0;
    end else if (xfer_c) begin
      {m_a_r, m_a_i, m_b_r, m_b_i} <= ops_sel_c;
    end
  end

  // Owner tags ride alongside the multiplier pipe; the last entry lines up with mr_*
  always_comb begin
    sr_vld_nxt_c    = {sr_vld[SR_LEN-2:0], xfer_c};
    sr_own_nxt_c    = {sr_own[SR_LEN-2:0], gnt_idx_c};
    res_fire_c      = sr_vld[SR_LEN-1] && !flush;
    res_valid_nxt_c = 2'b00;
    if (flush) begin
      sr_vld_nxt_c = '0;
    end
    if (res_fire_c) begin
      res_valid_nxt_c = sr_own[SR_LEN-1] ? 2'b10 : 2'b01;
    end
    busy_nxt_c = (|sr_vld_nxt_c) || (|res_valid_nxt_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld    <= '0;
      sr_own    <= '0;
      res_valid <= 2'b00;
      busy      <= 1'b0;
    end else begin
      sr_vld    <= sr_vld_nxt_c;
      sr_own    <= sr_own_nxt_c;
      res_valid <= res_valid_nxt_c;
      busy      <= busy_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= '0;
      res_i <= '0;
    end else if (res_fire_c) begin
      res_r <= mr_r;
      res_i <= mr_i;
    end
  end

`ifdef CMULT_ARB_STATS_EN
  // Saturating grant counters; only a hard reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (grant_c[k] && (grant_cnt[k] != 16'hFFFF)) begin
          grant_cnt[k] <= grant_cnt[k] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmult_arbiter.sv
// Self-checking bench for cmult_arbiter: vector table, directed corner cases and a randomized model run.
module tb_cmult_arbiter;
  import fft_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned L1 = 1;
  localparam int unsigned L4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              flush1, flush4;
  logic [1:0]        val1, val4, rdy1, rdy4, rv1, rv4;
  logic [1:0][63:0]  ops1, ops4;
  logic [DW-1:0]     ma_r1, ma_i1, mb_r1, mb_i1, mr_r1, mr_i1, res_r1, res_i1;
  logic [DW-1:0]     ma_r4, ma_i4, mb_r4, mb_i4, mr_r4, mr_i4, res_r4, res_i4;
  logic              busy1, busy4;
`ifdef CMULT_ARB_STATS_EN
  logic [1:0][15:0]  gc1, gc4;
`endif

  cmult_arbiter #(.MULT_LAT(L1), .DATA_W(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .req_valid(val1), .req_ready(rdy1),
    .req_ops(ops1), .m_a_r(ma_r1), .m_a_i(ma_i1), .m_b_r(mb_r1), .m_b_i(mb_i1),
    .mr_r(mr_r1), .mr_i(mr_i1), .res_valid(rv1), .res_r(res_r1), .res_i(res_i1),
    .busy(busy1)
`ifdef CMULT_ARB_STATS_EN
    , .grant_cnt(gc1)
`endif
  );

  cmult_arbiter #(.MULT_LAT(L4), .DATA_W(DW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .req_valid(val4), .req_ready(rdy4),
    .req_ops(ops4), .m_a_r(ma_r4), .m_a_i(ma_i4), .m_b_r(mb_r4), .m_b_i(mb_i4),
    .mr_r(mr_r4), .mr_i(mr_i4), .res_valid(rv4), .res_r(res_r4), .res_i(res_i4),
    .busy(busy4)
`ifdef CMULT_ARB_STATS_EN
    , .grant_cnt(gc4)
`endif
  );

  // Q1.15 complex product, standing in for the external multiplier
  function automatic logic [DW-1:0] cm_re(logic [DW-1:0] ar, logic [DW-1:0] ai,
                                          logic [DW-1:0] br, logic [DW-1:0] bi);
    logic signed [33:0] p;
    p = 34'($signed(ar) * $signed(br)) - 34'($signed(ai) * $signed(bi));
    return p[30:15];
  endfunction

  function automatic logic [DW-1:0] cm_im(logic [DW-1:0] ar, logic [DW-1:0] ai,
                                          logic [DW-1:0] br, logic [DW-1:0] bi);
    logic signed [33:0] p;
    p = 34'($signed(ar) * $signed(bi)) + 34'($signed(ai) * $signed(br));
    return p[30:15];
  endfunction

  logic [DW-1:0] p1_r [L1];
  logic [DW-1:0] p1_i [L1];
  logic [DW-1:0] p4_r [L4];
  logic [DW-1:0] p4_i [L4];

  always @(posedge clk) begin
    p1_r[0] <= cm_re(ma_r1, ma_i1, mb_r1, mb_i1);
    p1_i[0] <= cm_im(ma_r1, ma_i1, mb_r1, mb_i1);
    p4_r[0] <= cm_re(ma_r4, ma_i4, mb_r4, mb_i4);
    p4_i[0] <= cm_im(ma_r4, ma_i4, mb_r4, mb_i4);
    for (int s = 1; s < int'(L4); s++) begin
      p4_r[s] <= p4_r[s-1];
      p4_i[s] <= p4_i[s-1];
    end
  end
  assign mr_r1 = p1_r[L1-1];
  assign mr_i1 = p1_i[L1-1];
  assign mr_r4 = p4_r[L4-1];
  assign mr_i4 = p4_i[L4-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    val1 = 2'b00; val4 = 2'b00; flush1 = 1'b0; flush4 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] val;
    logic       fl;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic [1:0]    rv;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    int            due;
  } exp_t;

  vec_t        tbl [12];
  exp_t        q [$];
  cmult_ops_t  cop, last_op;
  cmult_ops_t  pops [2];
  logic [1:0]  pend;
  logic [1:0]  g;
  logic        rr_m;
  logic [63:0] last_m;
  logic [DW-1:0] last_r, last_i;
  int          edge_cnt;

  initial begin
    rst_n = 1'b0;
    flush1 = 1'b0; val1 = 2'b00; ops1 = '0;
    flush4 = 1'b0; val4 = 2'b00; ops4 = '0;
    #12;
    chk("rst_ready", 64'(rdy1), 64'd0);
    chk("rst_m", {ma_r1, ma_i1, mb_r1, mb_i1}, 64'd0);
    chk("rst_res", {32'd0, res_r1, res_i1}, 64'd0);
    chk("rst_res_valid", 64'(rv1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention, uncontested grants and flush from a fresh pointer (MULT_LAT=1)
    tbl[0]  = '{2'b11, 1'b0, 2'b01, 2'b00, 1'b1};
    tbl[1]  = '{2'b11, 1'b0, 2'b10, 2'b00, 1'b1};
    tbl[2]  = '{2'b11, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[3]  = '{2'b11, 1'b0, 2'b10, 2'b10, 1'b1};
    tbl[4]  = '{2'b01, 1'b0, 2'b01, 2'b01, 1'b1};
    tbl[5]  = '{2'b11, 1'b0, 2'b01, 2'b10, 1'b1};
    tbl[6]  = '{2'b10, 1'b0, 2'b10, 2'b01, 1'b1};
    tbl[7]  = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{2'b11, 1'b0, 2'b10, 2'b00, 1'b1};
    tbl[9]  = '{2'b01, 1'b0, 2'b01, 2'b00, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 1'b0, 2'b00, 2'b01, 1'b1};
    ops1[0] = {$urandom, $urandom};
    ops1[1] = {$urandom, $urandom};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      val1 = tbl[i].val;
      flush1 = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(rdy1), 64'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_res_valid", i), 64'(rv1), 64'(tbl[i].exp_rv));
      chk($sformatf("tbl%0d_busy", i), 64'(busy1), 64'(tbl[i].exp_busy));
    end

    // Single requester, Q1.15 0.5*0.5
    do_reset();
    @(negedge clk);
    val1 = 2'b01;
    ops1[0] = 64'h4000_0000_4000_0000;
    #1 chk("single_ready", 64'(rdy1), 64'd1);
    @(posedge clk); #1;
    chk("single_m", {ma_r1, ma_i1, mb_r1, mb_i1}, 64'h4000_0000_4000_0000);
    chk("single_rv_t0", 64'(rv1), 64'd0);
    val1 = 2'b00;
    @(posedge clk); #1;
    chk("single_rv_t1", 64'(rv1), 64'd0);
    @(posedge clk); #1;
    chk("single_rv_t2", 64'(rv1), 64'd1);
    chk("single_res", {32'd0, res_r1, res_i1}, 64'h2000_0000);
    @(posedge clk); #1;
    chk("single_rv_t3", 64'(rv1), 64'd0);
    chk("single_res_hold", {32'd0, res_r1, res_i1}, 64'h2000_0000);

    // Latency sweep on the MULT_LAT=4 instance
    do_reset();
    @(negedge clk);
    cop = {$urandom, $urandom};
    ops4[0] = cop;
    val4 = 2'b01;
    #1 chk("lat4_ready", 64'(rdy4), 64'd1);
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk); #1;
      val4 = 2'b00;
      chk($sformatf("lat4_rv_%0d", j), 64'(rv4), (j == 5) ? 64'd1 : 64'd0);
      chk($sformatf("lat4_busy_%0d", j), 64'(busy4), (j <= 5) ? 64'd1 : 64'd0);
      if (j == 5) begin
        chk("lat4_res", {32'd0, res_r4, res_i4},
            {32'd0, cm_re(cop.a.re, cop.a.im, cop.b.re, cop.b.im),
                    cm_im(cop.a.re, cop.a.im, cop.b.re, cop.b.im)});
      end
    end

    // Flush with three operations in flight
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      last_op = {$urandom, $urandom};
      ops4[0] = last_op;
      val4 = 2'b01;
    end
    @(negedge clk);
    ops4[0] = {$urandom, $urandom};
    flush4 = 1'b1;
    #1 chk("flush_ready", 64'(rdy4), 64'd0);
    @(posedge clk); #1;
    chk("flush_busy", 64'(busy4), 64'd0);
    chk("flush_rv", 64'(rv4), 64'd0);
    chk("flush_m_keep", {ma_r4, ma_i4, mb_r4, mb_i4}, 64'(last_op));
    @(negedge clk);
    flush4 = 1'b0;
    val4 = 2'b00;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      chk($sformatf("flush_quiet_%0d", j), {62'd0, rv4} | 64'(busy4), 64'd0);
    end

    // Asynchronous reset while operations are in flight
    do_reset();
    @(negedge clk);
    ops1[0] = {$urandom, $urandom};
    ops1[1] = {$urandom, $urandom};
    val1 = 2'b11;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(rdy1), 64'd0);
    chk("arst_m", {ma_r1, ma_i1, mb_r1, mb_i1}, 64'd0);
    chk("arst_res", {32'd0, res_r1, res_i1}, 64'd0);
    chk("arst_rv_busy", {62'd0, rv1} | 64'(busy1), 64'd0);
    @(negedge clk);
    val1 = 2'b00;
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk($sformatf("arst_quiet_%0d", j), {62'd0, rv1} | 64'(busy1), 64'd0);
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    rr_m = 1'b0; pend = 2'b00; last_m = '0; last_r = '0; last_i = '0;
    edge_cnt = 0; q.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && ($urandom_range(0, 99) < 60)) begin
          pend[k] = 1'b1;
          pops[k] = {$urandom, $urandom};
        end
        ops1[k] = pops[k];
      end
      val1 = pend;
      flush1 = ($urandom_range(0, 99) < 4);
      if (flush1)            g = 2'b00;
      else if (pend == 2'b11) g = rr_m ? 2'b10 : 2'b01;
      else                   g = pend;
      #1 chk("rnd_ready", 64'(rdy1), 64'(g));
      if (flush1) q.delete();
      if (pend == 2'b11 && !flush1) rr_m = ~rr_m;
      if (g != 2'b00) begin
        cop = g[1] ? pops[1] : pops[0];
        q.push_back('{g, cm_re(cop.a.re, cop.a.im, cop.b.re, cop.b.im),
                         cm_im(cop.a.re, cop.a.im, cop.b.re, cop.b.im),
                      edge_cnt + 1 + int'(L1) + 1});
        last_m = cop;
        pend = pend & ~g;
      end
      @(posedge clk); #1;
      edge_cnt++;
      chk("rnd_busy", 64'(busy1), 64'(q.size() > 0));
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        chk("rnd_res_valid", 64'(rv1), 64'(q[0].rv));
        last_r = q[0].r;
        last_i = q[0].i;
        void'(q.pop_front());
      end else begin
        chk("rnd_res_valid", 64'(rv1), 64'd0);
      end
      chk("rnd_res", {32'd0, res_r1, res_i1}, {32'd0, last_r, last_i});
      chk("rnd_m", {ma_r1, ma_i1, mb_r1, mb_i1}, last_m);
    end

`ifdef CMULT_ARB_STATS_EN
    // Saturation of the grant counter for requester 1
    do_reset();
    @(negedge clk);
    val1 = 2'b10;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    val1 = 2'b00;
    chk("stats_cnt1", 64'(gc1[1]), 64'hFFFF);
    chk("stats_cnt0", 64'(gc1[0]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmult_arbiter.md
# cmult_arbiter

Round-robin scheduler that shares one pipelined complex multiplier (four 16×16 `mult` IP cores feeding an adder and a subtractor) between two requesters, e.g. the twiddle stages of two FFT butterfly lanes. It accepts operand pairs over valid/ready handshakes and registers them onto the multiplier inputs. It tracks each operation's owner through the multiplier's fixed latency and returns each registered result only to the requester that issued it. Throughput is one complex multiply per cycle.

## Interface
- `MULT_LAT`, default 1: clock cycles from registered multiplier inputs to valid `mr_r`/`mr_i`; legal range 1–8.
- `DATA_W`, default 16: width of each real/imaginary component.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous; discards all in-flight operations.
- `req_valid[1:0]`, input, 2: operand pair offered by requester k.
- `req_ready[1:0]`, output, 2: requester k's pair is accepted this cycle.
- `req_ops[1:0]`, input, 2×4×DATA_W: per requester `{a_r, a_i, b_r, b_i}`.
- `m_a_r`, `m_a_i`, `m_b_r`, `m_b_i`, output, DATA_W each: registered operands to the complex multiplier.
- `mr_r`, `mr_i`, input, DATA_W each: product from the complex multiplier.
- `res_valid[1:0]`, output, 2: one-cycle pulse; result for requester k.
- `res_r`, `res_i`, output, DATA_W each: registered result, shared by both requesters.
- `busy`, output, 1: at least one operation is in flight.

## Operation
- **Grant rule.** At most one grant per cycle, so `req_ready` is one-hot or zero.
  - Only one `req_valid` high: that requester is granted.
  - Both high: the requester selected by pointer `rr` is granted.
- **Readiness.** `req_ready` is combinational from `req_valid`, `rr` and `flush`; no dependence on result consumption (no backpressure on results).
- **Handshake.**
  - Transfer occurs when `req_valid[k] && req_ready[k]`.
  - A requester must hold `req_valid` and `req_ops` stable until accepted.
  - Once a request is offered, it may not be withdrawn.
- **Round-robin pointer.**
  - `rr` flips to the other requester only after a contested grant (both valid).
  - Uncontested grants leave `rr` unchanged.
  - Reset value of `rr` is 0.
- **Operand stage.**
  - On an accepted transfer, the granted `req_ops` are registered into `m_*`.
  - With no transfer, `m_*` hold their previous value; the multiplier computes garbage that is never tagged valid.
- **Owner tracking.** A shift register of MULT_LAT+1 entries, each `{vld, owner}`, advances every cycle.
  - Entry 0 is loaded with `{transfer, granted_k}`.
  - The last entry aligns with `mr_r`/`mr_i`.
- **Result stage.**
  - When the last entry's `vld` is set, `mr_r`/`mr_i` are registered into `res_r`/`res_i`.
  - `res_valid[owner]` is asserted for exactly one cycle.
  - Otherwise `res_valid = 0` and `res_r`/`res_i` hold their previous value.
- **Arithmetic.** No arithmetic or truncation inside this block; scaling (the Q1.15 product slice) is owned by the multiplier. Widths pass through unchanged.
- **`busy`.** Asserted when any shift-register `vld` bit is set or `res_valid` is nonzero.
- **Flush.**
  - During a `flush` cycle, `req_ready = 0`.
  - On the next edge, all `vld` bits clear and `res_valid` clears.
  - `rr` and `m_*` are unaffected.
- **Reset values.** All outputs are 0: `req_ready`, `m_*`, `res_valid`, `res_r`, `res_i`, `busy`.
- **Reset mid-operation.** In-flight operations are lost without producing any `res_valid`.

## Timing
- Accepted at edge T → `m_*` valid after T → product at `mr_*` after T+MULT_LAT → `res_valid` high after edge T+MULT_LAT+1.
- Total handshake-to-result latency is MULT_LAT+2 cycles.
- Back-to-back accepts produce back-to-back `res_valid` pulses, in acceptance order.
- `flush` and an incoming request in the same cycle: the request is not accepted.

## Configuration
- **`CMULT_ARB_STATS_EN` defined:** adds output `grant_cnt[1:0]`, 2×16-bit.
  - Counter k increments on each grant to requester k and saturates at 0xFFFF.
  - Counters clear on `rst_n` only, not on `flush`.
- **Not defined:** the port and counters are absent; behaviour is otherwise identical.

## Structure
- **Shared package `fft_pkg`:**
  - `DATA_W`.
  - Typedef `cplx_t` {re, im}.
  - Typedef `cmult_ops_t` {a, b}.
  - Localparam `CMULT_LAT_DEFAULT = 1`.
- **Sub-module `rr_arb2`:** natural split for the two-way round-robin grant and pointer.
- **Parent-level assembly:** the owner shift register and result stage stay in the parent. The multiplier itself is instantiated outside, next to this block.

## Test plan
- **Single requester:** MULT_LAT=1, req0 `{a=(0x4000,0), b=(0x4000,0)}` → `res_valid=2'b01` 3 cycles later, `res_r=0x2000`, `res_i=0`.
- **Contention:** both valid continuously for 4 cycles from reset → grants alternate 0,1,0,1; `res_valid` pulses 01,10,01,10 on consecutive cycles.
- **Latency sweep:** MULT_LAT=4, one request → `res_valid` exactly 6 cycles after the handshake; `busy` high for those 6 cycles.
- **Flush:** three requests in flight, then `flush` for 1 cycle → no `res_valid`, `busy` low the next cycle, `req_ready=0` during the flush cycle.
- **Async reset mid-stream:** `rst_n` low between edges while operations are in flight → all outputs 0 immediately; no results after release.
- **Stats:** with `CMULT_ARB_STATS_EN`, 70000 grants to req1 → `grant_cnt[1]=0xFFFF`, `grant_cnt[0]=0`.
